// File: rtl/sha1_msg_loader.sv
// Writer side of the SHA-1 message RAM: packs a byte stream big-endian into words 0..15,
// appends single-block padding and the bit length, then hands the block to the controller.
module sha1_msg_loader #(
    parameter int MAX_BYTES = 55,
    parameter int ADDR_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] waddr,
    output logic              we,
    output logic [31:0]       din,
    output logic              start,
    input  logic              core_done,
    output logic              busy,
    output logic              msg_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_PAD       = 3'd2,
        S_LEN_HI    = 3'd3,
        S_LEN_LO    = 3'd4,
        S_START     = 3'd5,
        S_WAIT_DONE = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    localparam logic [5:0] OVF_CNT = 6'(MAX_BYTES + 1);

    state_t        state_r, state_n;
    logic [5:0]    bcnt_r, bcnt_n, cnt_inc_s;
    logic [23:0]   wbuf_r, wbuf_n;
    logic [3:0]    naddr_r, naddr_n;
    logic          marker_r, marker_n;
    logic          msg_err_r, err_n;
    logic          we_r, waddr_unused_s;
    logic [ADDR_W-1:0] waddr_r;
    logic [31:0]   din_r;
    logic          start_r, start_n;
    logic          busy_r, in_ready_r;
    logic          accept_s, wr_en_s;
    logic [3:0]    wr_addr_s;
    logic [31:0]   wr_data_s;

    // Final word of the message: pending bytes, new byte, then the 0x80 marker if it fits.
    function automatic logic [31:0] last_word(input logic [1:0] pos, input logic [23:0] buf_v,
                                              input logic [7:0] b);
        case (pos)
            2'd0:    last_word = {b, 8'h80, 16'h0000};
            2'd1:    last_word = {buf_v[7:0], b, 8'h80, 8'h00};
            2'd2:    last_word = {buf_v[15:0], b, 8'h80};
            2'd3:    last_word = {buf_v, b};
            default: last_word = 32'h0000_0000;
        endcase
    endfunction

    assign accept_s       = in_valid & in_ready_r;
    assign cnt_inc_s      = bcnt_r + 6'd1;
    assign waddr_unused_s = 1'b0;

    // Next-state, counter and write-request logic.
    always_comb begin
        state_n   = state_r;
        bcnt_n    = bcnt_r;
        wbuf_n    = wbuf_r;
        naddr_n   = naddr_r;
        marker_n  = marker_r;
        err_n     = msg_err_r;
        start_n   = 1'b0;
        wr_en_s   = 1'b0;
        wr_addr_s = 4'd0;
        wr_data_s = 32'h0000_0000;
        case (state_r)
            S_IDLE, S_LOAD: begin
                if (accept_s) begin
                    if (state_r == S_IDLE) begin
                        err_n = 1'b0;
                    end else begin
                        err_n = msg_err_r;
                    end
                    bcnt_n    = cnt_inc_s;
                    wr_addr_s = bcnt_r[5:2];
                    if (cnt_inc_s == OVF_CNT) begin
                        // Overflow byte still completes its word but nothing follows it.
                        wr_en_s   = (bcnt_r[1:0] == 2'd3);
                        wr_data_s = {wbuf_r, in_data};
                        wbuf_n    = 24'h00_0000;
                        err_n     = 1'b1;
                        if (in_last) begin
                            state_n = S_IDLE;
                            bcnt_n  = 6'd0;
                        end else begin
                            state_n = S_ERR;
                        end
                    end else if (in_last) begin
                        wr_en_s   = 1'b1;
                        wr_data_s = last_word(bcnt_r[1:0], wbuf_r, in_data);
                        wbuf_n    = 24'h00_0000;
                        naddr_n   = bcnt_r[5:2] + 4'd1;
                        marker_n  = (bcnt_r[1:0] == 2'd3);
                        state_n   = S_PAD;
                    end else begin
                        if (bcnt_r[1:0] == 2'd3) begin
                            wr_en_s   = 1'b1;
                            wr_data_s = {wbuf_r, in_data};
                            wbuf_n    = 24'h00_0000;
                        end else begin
                            wbuf_n = {wbuf_r[15:0], in_data};
                        end
                        state_n = S_LOAD;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            S_PAD: begin
                if (marker_r || (naddr_r != 4'd14)) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = naddr_r;
                    if (marker_r) begin
                        wr_data_s = 32'h8000_0000;
                    end else begin
                        wr_data_s = 32'h0000_0000;
                    end
                    marker_n = 1'b0;
                    naddr_n  = naddr_r + 4'd1;
                    if (naddr_r == 4'd13) begin
                        state_n = S_LEN_HI;
                    end else begin
                        state_n = S_PAD;
                    end
                end else begin
                    state_n = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                wr_en_s   = 1'b1;
                wr_addr_s = 4'd14;
                state_n   = S_LEN_LO;
            end
            S_LEN_LO: begin
                wr_en_s   = 1'b1;
                wr_addr_s = 4'd15;
                wr_data_s = {23'd0, bcnt_r, 3'd0};
                state_n   = S_START;
            end
            S_START: begin
                start_n = 1'b1;
                state_n = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (core_done) begin
                    state_n  = S_IDLE;
                    bcnt_n   = 6'd0;
                    wbuf_n   = 24'h00_0000;
                    naddr_n  = 4'd0;
                    marker_n = 1'b0;
                end else begin
                    state_n = S_WAIT_DONE;
                end
            end
            S_ERR: begin
                if (accept_s && in_last) begin
                    state_n = S_IDLE;
                    bcnt_n  = 6'd0;
                    wbuf_n  = 24'h00_0000;
                end else begin
                    state_n = S_ERR;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            bcnt_r     <= 6'd0;
            wbuf_r     <= 24'h00_0000;
            naddr_r    <= 4'd0;
            marker_r   <= 1'b0;
            msg_err_r  <= 1'b0;
            we_r       <= 1'b0;
            waddr_r    <= '0;
            din_r      <= 32'h0000_0000;
            start_r    <= 1'b0;
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            bcnt_r     <= bcnt_n;
            wbuf_r     <= wbuf_n;
            naddr_r    <= naddr_n;
            marker_r   <= marker_n;
            msg_err_r  <= err_n;
            we_r       <= wr_en_s;
            waddr_r    <= {{(ADDR_W-4){waddr_unused_s}}, wr_addr_s};
            din_r      <= wr_data_s;
            start_r    <= start_n;
            busy_r     <= (state_n != S_IDLE);
            in_ready_r <= (state_n == S_IDLE) || (state_n == S_LOAD) || (state_n == S_ERR);
        end
    end

    assign in_ready = in_ready_r;
    assign waddr    = waddr_r;
    assign we       = we_r;
    assign din      = din_r;
    assign start    = start_r;
    assign busy     = busy_r;
    assign msg_err  = msg_err_r;

endmodule

// File: tb/tb_sha1_msg_loader.sv
// Directed bench for sha1_msg_loader: a write monitor rebuilds the RAM image, which is
// compared against a padded-block reference plus hand-computed constants.
module tb_sha1_msg_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_last, in_ready, we, start, core_done, busy, msg_err;
    logic [7:0]  in_data;
    logic [6:0]  waddr;
    logic [31:0] din;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  msg   [64];
    logic [31:0] exp_w [16];
    logic [31:0] ram   [16];
    int          wr_cnt[16];
    int          total_wr, start_cnt, bad_addr;
    logic        clr = 1'b0;

    sha1_msg_loader #(.MAX_BYTES(55), .ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .waddr(waddr), .we(we), .din(din), .start(start),
        .core_done(core_done), .busy(busy), .msg_err(msg_err)
    );

    always #5 clk = ~clk;

    // RAM write monitor and start counter.
    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) begin
                ram[i]    <= 32'hDEAD_BEEF;
                wr_cnt[i] <= 0;
            end
            total_wr  <= 0;
            start_cnt <= 0;
            bad_addr  <= 0;
        end else begin
            if (we) begin
                total_wr <= total_wr + 1;
                if (waddr < 7'd16) begin
                    ram[waddr[3:0]]    <= din;
                    wr_cnt[waddr[3:0]] <= wr_cnt[waddr[3:0]] + 1;
                end else begin
                    bad_addr <= bad_addr + 1;
                end
            end
            if (start) start_cnt <= start_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_model();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        if (gap > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic send_msg(input int len, input int gap);
        for (int i = 0; i < len; i++)
            send_byte(msg[i], (i == len - 1), (i == len - 1) ? 0 : gap);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic build_exp(input int len);
        logic [7:0]  pb[64];
        logic [15:0] bits;
        for (int i = 0; i < 64; i++) pb[i] = (i < len) ? msg[i] : 8'h00;
        pb[len] = 8'h80;
        bits    = 16'(len * 8);
        pb[62]  = bits[15:8];
        pb[63]  = bits[7:0];
        for (int k = 0; k < 16; k++)
            exp_w[k] = {pb[4*k], pb[4*k+1], pb[4*k+2], pb[4*k+3]};
    endtask

    task automatic wait_start(input string tag);
        int t = 0;
        while (start_cnt == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_starts"}, 32'(start_cnt), 32'd1);
        check({tag, "_writes"}, 32'(total_wr), 32'd16);
    endtask

    task automatic check_image(input string tag, input int len);
        build_exp(len);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_w%0d", tag, k), ram[k], exp_w[k]);
            check($sformatf("%s_cnt%0d", tag, k), 32'(wr_cnt[k]), 32'd1);
        end
    endtask

    task automatic finish_core(input string tag);
        check({tag, "_rdy_wait"}, 32'(in_ready), 32'd0);
        check({tag, "_busy_wait"}, 32'(busy), 32'd1);
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic load_abc();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h64;
    endtask

    initial begin
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; core_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(msg_err), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_din", din, 32'd0);
        rst = 1'b0;
        clear_model();
        check("post_rst_rdy", 32'(in_ready), 32'd1);

        // "abc", continuous valid
        load_abc();
        send_msg(3, 0);
        wait_start("abc");
        check_image("abc", 3);
        check("abc_w0_hand", ram[0], 32'h6162_6380);
        check("abc_w15_hand", ram[15], 32'h0000_0018);
        finish_core("abc");

        // "abcd": marker spills into word 1
        clear_model();
        load_abc();
        send_msg(4, 0);
        wait_start("abcd");
        check_image("abcd", 4);
        check("abcd_w1_hand", ram[1], 32'h8000_0000);
        check("abcd_w15_hand", ram[15], 32'h0000_0020);
        finish_core("abcd");

        // 55 bytes: no zero-fill writes
        clear_model();
        for (int i = 0; i < 64; i++) msg[i] = 8'(i);
        send_msg(55, 0);
        wait_start("m55");
        check_image("m55", 55);
        check("m55_w13_hand", ram[13], 32'h3435_3680);
        check("m55_w15_hand", ram[15], 32'h0000_01B8);
        finish_core("m55");

        // 56 bytes: overflow, no length, no start
        clear_model();
        send_msg(56, 0);
        repeat (40) @(negedge clk);
        check("m56_starts", 32'(start_cnt), 32'd0);
        check("m56_writes", 32'(total_wr), 32'd14);
        check("m56_w13", ram[13], 32'h3435_3637);
        check("m56_w0", ram[0], 32'h0001_0203);
        check("m56_cnt14", 32'(wr_cnt[14]), 32'd0);
        check("m56_cnt15", 32'(wr_cnt[15]), 32'd0);
        check("m56_err", 32'(msg_err), 32'd1);
        check("m56_busy", 32'(busy), 32'd0);
        clear_model();
        load_abc();
        send_msg(3, 0);
        check("m56_err_clr", 32'(msg_err), 32'd0);
        wait_start("after56");
        check_image("after56", 3);
        finish_core("after56");

        // "abc" with 3-cycle valid gaps
        clear_model();
        send_msg(3, 3);
        wait_start("gap");
        check_image("gap", 3);
        finish_core("gap");

        // reset after 6 bytes of a 20-byte message
        clear_model();
        for (int i = 0; i < 20; i++) msg[i] = 8'(8'h10 + i);
        for (int i = 0; i < 6; i++) send_byte(msg[i], 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = msg[6];
        #2 rst = 1'b1;
        #1;
        check("mid_rst_we", 32'(we), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rdy", 32'(in_ready), 32'd0);
        check("mid_rst_waddr", 32'(waddr), 32'd0);
        check("mid_rst_din", din, 32'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_rst_starts", 32'(start_cnt), 32'd0);
        clear_model();
        load_abc();
        send_msg(3, 0);
        wait_start("post_rst");
        check_image("post_rst", 3);
        finish_core("post_rst");

        check("bad_addr", 32'(bad_addr), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
